img_upscaler: RTL and testbench
===============================

# img_upscaler

Nearest-neighbour upscaler: the inverse end of the image resizer's output stream. It accepts one RSZ_IMG_HEIGHT_SIZE × RSZ_IMG_WIDTH_SIZE resized frame, serial raster order, valid/ready, into an internal buffer. It then streams a full-size frame of img_width_i × img_height_i pixels, replicating each resized pixel over its block. It sits downstream of the resizer's serial forwarding port and is used for display or loopback checking.

## Interface
Parameters:
- IMG_WIDTH_MAX_SIZE, 1024, maximum output width; IMG_WIDTH_IDX_W = $clog2 of it
- IMG_HEIGHT_MAX_SIZE, 1024, maximum output height; IMG_HEIGHT_IDX_W = $clog2 of it
- RSZ_IMG_WIDTH_SIZE, 8, resized width (power of two); RSZ_IMG_WIDTH_IDX_W = $clog2 of it
- RSZ_IMG_HEIGHT_SIZE, 8, resized height (power of two); RSZ_IMG_HEIGHT_IDX_W = $clog2 of it
- PXL_PRIM_COLOR_NUM, 1, primary colours per pixel
- PXL_PRIM_COLOR_W, 8, bits per primary colour; PXL_W = PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W

Ports:
- clk  in  1  clock; the block has one clock and reset is synchronous, active-low
- rst_n  in  1  synchronous active-low reset
- img_width_i  in  IMG_WIDTH_IDX_W+1  output frame width, sampled on first input handshake of a frame
- img_height_i  in  IMG_HEIGHT_IDX_W+1  output frame height, sampled with img_width_i
- rsz_pxl_data_i  in  PXL_W  resized pixel, colour 0 in LSBs
- rsz_pxl_vld_i  in  1  resized pixel valid
- rsz_pxl_rdy_o  out  1  ready to accept resized pixel
- pxl_data_o  out  PXL_W  upscaled pixel
- pxl_vld_o  out  1  upscaled pixel valid
- pxl_rdy_i  in  1  downstream ready
- pxl_eol_o  out  1  qualifies pxl_vld_o: last pixel of a row
- pxl_eof_o  out  1  qualifies pxl_vld_o: last pixel of the frame
- busy_o  out  1  high from first input handshake until the EOF output handshake

## Operation
- States: LOAD, EMIT.
- LOAD: rsz_pxl_rdy_o=1. Each handshake writes buf[ld_row][ld_col], raster order (col fastest). On the first handshake (ld_row=ld_col=0), latch the dimensions.
  - blk_w = img_width_i >> RSZ_IMG_WIDTH_IDX_W; blk_h likewise with the height parameters.
  - A value of 0 becomes 1. Values above the maximum saturate to IMG_*_MAX_SIZE before the shift.
  - Low bits below the shift amount are ignored, so the output width = blk_w*RSZ_IMG_WIDTH_SIZE.
- The final input handshake (index RSZ_IMG_HEIGHT_SIZE*RSZ_IMG_WIDTH_SIZE-1) moves to EMIT. Load counters clear.
- EMIT: rsz_pxl_rdy_o=0. Four counters advance on each output handshake: sub_col (0..blk_w-1) → rsz_col (0..RSZ_W-1) → sub_row (0..blk_h-1) → rsz_row (0..RSZ_H-1). The output pixel is buf[rsz_row][rsz_col].
  - pxl_eol_o = sub_col and rsz_col both at their maxima.
  - pxl_eof_o = eol and sub_row and rsz_row both at their maxima.
- The EOF output handshake returns to LOAD and clears all counters and busy_o.
- Single buffer: no overlap between loading and emitting. Input stalls during EMIT.
- Dimension inputs changing mid-frame have no effect.

## Timing
- Reset values: rsz_pxl_rdy_o=1 (state LOAD), pxl_vld_o=0, pxl_data_o=0, pxl_eol_o=0, pxl_eof_o=0, busy_o=0, all counters 0. Buffer contents are undefined. Reset mid-frame discards the partial frame.
- pxl_data_o, pxl_vld_o, pxl_eol_o and pxl_eof_o are registered.
- pxl_vld_o first rises one cycle after the final input handshake.
- While pxl_vld_o=1 and pxl_rdy_i=0, all outputs hold stable.
- Throughput is 1 pixel/cycle while pxl_rdy_i=1. No bubbles inside a frame.
- After the EOF handshake, pxl_vld_o=0 and rsz_pxl_rdy_o=1 on the next cycle.
- busy_o rises the cycle after the first input handshake.
- Total output pixels = blk_w*blk_h*RSZ_W*RSZ_H.

## Test plan
- Defaults, width=height=16, input pixels 0..63, pxl_rdy_i=1 → 256 outputs. Row r col c equals (r>>1)*8+(c>>1). eol on every 16th output, eof on the 256th. vld first high 1 cycle after input #63.
- width=8, height=8 → output is an identity copy of the 64 inputs. eol every 8th output. Back-to-back second frame accepted immediately after eof.
- width=1024, height=8 → blk_w=128, blk_h=1. 8192 outputs. Pixel 127 = in[0], pixel 128 = in[1].
- Random pxl_rdy_i (50%) and random gaps on rsz_pxl_vld_i → data held stable under stall. No input accepted during EMIT. Sequence identical to the no-stall run.
- width=20, height=0 → treated as 16 × 8 (blk_w=2, blk_h=1): 128 outputs. width=2047 → saturates to 1024.
- rst_n low for 1 cycle after input #30 → rsz_pxl_rdy_o=1 and busy_o=0 next cycle. A fresh 64-pixel frame emits correctly with no stale data.

Source files
------------

// File: rtl/img_upscaler_if.sv
// Pixel stream bundle for the upscaler: resized pixels in, full-size pixels out.
// The DUT side uses the slave modport and the source/sink side uses master.
interface img_upscaler_if #(
    parameter int unsigned PXL_W = 8
);
    logic [PXL_W-1:0] rsz_pxl_data_i;
    logic             rsz_pxl_vld_i;
    logic             rsz_pxl_rdy_o;
    logic [PXL_W-1:0] pxl_data_o;
    logic             pxl_vld_o;
    logic             pxl_rdy_i;
    logic             pxl_eol_o;
    logic             pxl_eof_o;

    modport master (
        output rsz_pxl_data_i, rsz_pxl_vld_i, pxl_rdy_i,
        input  rsz_pxl_rdy_o, pxl_data_o, pxl_vld_o, pxl_eol_o, pxl_eof_o
    );

    modport slave (
        input  rsz_pxl_data_i, rsz_pxl_vld_i, pxl_rdy_i,
        output rsz_pxl_rdy_o, pxl_data_o, pxl_vld_o, pxl_eol_o, pxl_eof_o
    );
endinterface

// File: rtl/img_upscaler.sv
// Nearest-neighbour upscaler: buffers one resized frame, then replays each
// stored pixel over a blk_w x blk_h block of the full-size output frame.
module img_upscaler #(
    parameter int unsigned IMG_WIDTH_MAX_SIZE   = 1024,
    parameter int unsigned IMG_HEIGHT_MAX_SIZE  = 1024,
    parameter int unsigned RSZ_IMG_WIDTH_SIZE   = 8,
    parameter int unsigned RSZ_IMG_HEIGHT_SIZE  = 8,
    parameter int unsigned PXL_PRIM_COLOR_NUM   = 1,
    parameter int unsigned PXL_PRIM_COLOR_W     = 8,
    localparam int unsigned IMG_WIDTH_IDX_W      = $clog2(IMG_WIDTH_MAX_SIZE),
    localparam int unsigned IMG_HEIGHT_IDX_W     = $clog2(IMG_HEIGHT_MAX_SIZE),
    localparam int unsigned RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE),
    localparam int unsigned RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
    localparam int unsigned PXL_W                = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IMG_WIDTH_IDX_W:0]  img_width_i,
    input  logic [IMG_HEIGHT_IDX_W:0] img_height_i,
    img_upscaler_if.slave             bus,
    output logic                      busy_o
);

    localparam int unsigned WW = IMG_WIDTH_IDX_W + 1;
    localparam int unsigned HW = IMG_HEIGHT_IDX_W + 1;
    localparam int unsigned CW = RSZ_IMG_WIDTH_IDX_W;
    localparam int unsigned RW = RSZ_IMG_HEIGHT_IDX_W;
    localparam int unsigned DEPTH = RSZ_IMG_HEIGHT_SIZE * RSZ_IMG_WIDTH_SIZE;

    localparam logic [WW-1:0]    W_MAX    = WW'(IMG_WIDTH_MAX_SIZE);
    localparam logic [HW-1:0]    H_MAX    = HW'(IMG_HEIGHT_MAX_SIZE);
    localparam logic [CW-1:0]    COL_LAST = CW'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(RSZ_IMG_HEIGHT_SIZE - 1);
    localparam logic [RW+CW-1:0] ADDR0    = '0;

    typedef enum logic {
        LOAD,
        EMIT
    } state_t;

    state_t state;
    state_t stateNext;

    logic [PXL_W-1:0] pixBuf [DEPTH];

    logic [CW-1:0] ldCol;
    logic [RW-1:0] ldRow;
    logic [WW-1:0] blkW;
    logic [HW-1:0] blkH;
    logic          busy;

    logic [WW-1:0] subCol, subColNext;
    logic [CW-1:0] rszCol, rszColNext;
    logic [HW-1:0] subRow, subRowNext;
    logic [RW-1:0] rszRow, rszRowNext;

    logic [PXL_W-1:0] pxlData;
    logic             pxlVld;
    logic             pxlEol;
    logic             pxlEof;
    logic             rszRdy;

    logic [WW-1:0] satW, shW, blkWIn;
    logic [HW-1:0] satH, shH, blkHIn;

    logic inHs, outHs, ldFirst, ldLast;
    logic nextEol, nextEof, firstEol, firstEof;

    assign inHs    = bus.rsz_pxl_vld_i && (state == LOAD);
    assign outHs   = pxlVld && bus.pxl_rdy_i;
    assign ldFirst = inHs && (ldRow == '0) && (ldCol == '0);
    assign ldLast  = inHs && (ldRow == ROW_LAST) && (ldCol == COL_LAST);

    // Saturate before the shift so oversize requests collapse to the largest block.
    always_comb begin
        satW   = (img_width_i  > W_MAX) ? W_MAX : img_width_i;
        satH   = (img_height_i > H_MAX) ? H_MAX : img_height_i;
        shW    = satW >> CW;
        shH    = satH >> RW;
        blkWIn = (shW == '0) ? WW'(1) : shW;
        blkHIn = (shH == '0) ? HW'(1) : shH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        rszRdy    = 1'b0;
        case (state)
            LOAD: begin
                rszRdy = 1'b1;
                if (bus.rsz_pxl_vld_i && (ldRow == ROW_LAST) && (ldCol == COL_LAST)) begin
                    stateNext = EMIT;
                end
            end
            EMIT: begin
                if (pxlVld && bus.pxl_rdy_i && pxlEof) begin
                    stateNext = LOAD;
                end
            end
        endcase
    end

    // Load side: raster write pointer, dimension latch and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ldCol <= '0;
            ldRow <= '0;
            blkW  <= WW'(1);
            blkH  <= HW'(1);
            busy  <= 1'b0;
        end else begin
            if (inHs) begin
                ldCol <= ldCol + 1'b1;
                if (ldCol == COL_LAST) begin
                    ldRow <= ldRow + 1'b1;
                end
            end
            if (ldFirst) begin
                blkW <= blkWIn;
                blkH <= blkHIn;
                busy <= 1'b1;
            end
            if (outHs && pxlEof) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (inHs) begin
            pixBuf[{ldRow, ldCol}] <= bus.rsz_pxl_data_i;
        end
    end

    // Counter cascade: sub_col -> rsz_col -> sub_row -> rsz_row.
    always_comb begin
        subColNext = subCol + 1'b1;
        rszColNext = rszCol;
        subRowNext = subRow;
        rszRowNext = rszRow;
        if (subCol == blkW - 1'b1) begin
            subColNext = '0;
            rszColNext = rszCol + 1'b1;
            if (rszCol == COL_LAST) begin
                subRowNext = subRow + 1'b1;
                if (subRow == blkH - 1'b1) begin
                    subRowNext = '0;
                    rszRowNext = rszRow + 1'b1;
                end
            end
        end
    end

    // Flags are registered alongside the data, so they are derived from the
    // counter values the next output will carry.
    always_comb begin
        nextEol  = (subColNext == blkW - 1'b1) && (rszColNext == COL_LAST);
        nextEof  = nextEol && (subRowNext == blkH - 1'b1) && (rszRowNext == ROW_LAST);
        firstEol = (blkW == WW'(1)) && (COL_LAST == '0);
        firstEof = firstEol && (blkH == HW'(1)) && (ROW_LAST == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            subCol  <= '0;
            rszCol  <= '0;
            subRow  <= '0;
            rszRow  <= '0;
            pxlVld  <= 1'b0;
            pxlData <= '0;
            pxlEol  <= 1'b0;
            pxlEof  <= 1'b0;
        end else if (ldLast) begin
            subCol  <= '0;
            rszCol  <= '0;
            subRow  <= '0;
            rszRow  <= '0;
            pxlVld  <= 1'b1;
            pxlData <= pixBuf[ADDR0];
            pxlEol  <= firstEol;
            pxlEof  <= firstEof;
        end else if (outHs) begin
            if (pxlEof) begin
                subCol <= '0;
                rszCol <= '0;
                subRow <= '0;
                rszRow <= '0;
                pxlVld <= 1'b0;
                pxlEol <= 1'b0;
                pxlEof <= 1'b0;
            end else begin
                subCol  <= subColNext;
                rszCol  <= rszColNext;
                subRow  <= subRowNext;
                rszRow  <= rszRowNext;
                pxlData <= pixBuf[{rszRowNext, rszColNext}];
                pxlEol  <= nextEol;
                pxlEof  <= nextEof;
            end
        end
    end

    assign bus.rsz_pxl_rdy_o = rszRdy;
    assign bus.pxl_data_o    = pxlData;
    assign bus.pxl_vld_o     = pxlVld;
    assign bus.pxl_eol_o     = pxlEol;
    assign bus.pxl_eof_o     = pxlEof;
    assign busy_o            = busy;

endmodule

// File: tb/tb_img_upscaler.sv
// Directed bench for img_upscaler: table of frame configurations replayed
// against a block-replication model, plus a mid-frame reset sequence.
module tb_img_upscaler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] imgWidth;
    logic [10:0] imgHeight;
    logic        busy;

    img_upscaler_if #(.PXL_W(8)) ifc ();

    img_upscaler #(
        .IMG_WIDTH_MAX_SIZE  (1024),
        .IMG_HEIGHT_MAX_SIZE (1024),
        .RSZ_IMG_WIDTH_SIZE  (8),
        .RSZ_IMG_HEIGHT_SIZE (8),
        .PXL_PRIM_COLOR_NUM  (1),
        .PXL_PRIM_COLOR_W    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .img_width_i  (imgWidth),
        .img_height_i (imgHeight),
        .bus          (ifc),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned w;
        int unsigned h;
        int unsigned bw;
        int unsigned bh;
        bit          stall;
        int unsigned seed;
    } vec_t;

    int unsigned nCompared   = 0;
    int unsigned nMismatched = 0;
    logic [7:0]  pix [64];
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Caller is positioned at a negedge with the DUT idle in LOAD.
    task automatic runFrame(input vec_t v, input int unsigned tag);
        int unsigned idx;
        int unsigned budget;
        int unsigned total;
        int unsigned outW;
        int unsigned outIdx;
        int unsigned r;
        int unsigned c;
        logic [11:0] expOut;
        logic [11:0] actOut;

        for (int i = 0; i < 64; i++) pix[i] = 8'(i + v.seed);
        imgWidth  = 11'(v.w);
        imgHeight = 11'(v.h);
        check($sformatf("f%0d idle", tag), {30'd0, busy, ifc.rsz_pxl_rdy_o}, 32'h1);

        idx = 0;
        budget = 0;
        while (idx < 64 && budget < 2000) begin
            if (v.stall && $urandom_range(0, 2) == 0) begin
                ifc.rsz_pxl_vld_i  = 1'b0;
                ifc.rsz_pxl_data_i = 8'hA5;
            end else begin
                ifc.rsz_pxl_vld_i  = 1'b1;
                ifc.rsz_pxl_data_i = pix[idx];
                if (ifc.rsz_pxl_rdy_o) idx++;
            end
            @(negedge clk);
            budget++;
            if (idx >= 1) begin
                imgWidth  = 11'($urandom);
                imgHeight = 11'($urandom);
            end
        end
        check($sformatf("f%0d load_count", tag), idx, 64);

        // Junk offered during EMIT in stall runs must never be taken.
        ifc.rsz_pxl_vld_i  = v.stall;
        ifc.rsz_pxl_data_i = 8'hEE;
        check($sformatf("f%0d first_vld_busy", tag), {30'd0, ifc.pxl_vld_o, busy}, 32'h3);

        total  = v.bw * v.bh * 64;
        outW   = v.bw * 8;
        outIdx = 0;
        budget = 0;
        while (outIdx < total && budget < total * 4 + 100) begin
            r = outIdx / outW;
            c = outIdx % outW;
            expOut = {1'b0, 1'b1, (c == outW - 1), (outIdx == total - 1),
                      pix[(r / v.bh) * 8 + c / v.bw]};
            actOut = {ifc.rsz_pxl_rdy_o, ifc.pxl_vld_o, ifc.pxl_eol_o, ifc.pxl_eof_o, ifc.pxl_data_o};
            check($sformatf("f%0d out[%0d] {rdyIn,vld,eol,eof,data}", tag, outIdx), actOut, expOut);
            ifc.pxl_rdy_i = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ifc.pxl_rdy_i) outIdx++;
            if (outIdx == total) ifc.rsz_pxl_vld_i = 1'b0;
            @(negedge clk);
            budget++;
        end
        check($sformatf("f%0d out_count", tag), outIdx, total);
        ifc.rsz_pxl_vld_i = 1'b0;
        ifc.pxl_rdy_i     = 1'b1;
        check($sformatf("f%0d after_eof {vld,rdyIn,busy}", tag),
              {29'd0, ifc.pxl_vld_o, ifc.rsz_pxl_rdy_o, busy}, 32'h2);
    endtask

    initial begin
        vecs[0] = '{w: 16,   h: 16,  bw: 2,   bh: 2, stall: 1'b0, seed: 0};
        vecs[1] = '{w: 8,    h: 8,   bw: 1,   bh: 1, stall: 1'b0, seed: 5};
        vecs[2] = '{w: 8,    h: 8,   bw: 1,   bh: 1, stall: 1'b0, seed: 77};
        vecs[3] = '{w: 1024, h: 8,   bw: 128, bh: 1, stall: 1'b0, seed: 9};
        vecs[4] = '{w: 16,   h: 16,  bw: 2,   bh: 2, stall: 1'b1, seed: 0};
        vecs[5] = '{w: 20,   h: 0,   bw: 2,   bh: 1, stall: 1'b0, seed: 33};
        vecs[6] = '{w: 2047, h: 8,   bw: 128, bh: 1, stall: 1'b0, seed: 200};
        vecs[7] = '{w: 31,   h: 17,  bw: 3,   bh: 2, stall: 1'b1, seed: 61};

        rst_n              = 1'b0;
        imgWidth           = '0;
        imgHeight          = '0;
        ifc.rsz_pxl_vld_i  = 1'b0;
        ifc.rsz_pxl_data_i = '0;
        ifc.pxl_rdy_i      = 1'b1;
        repeat (3) @(negedge clk);
        check("reset {rdyIn,vld,eol,eof,busy,data}",
              {ifc.rsz_pxl_rdy_o, ifc.pxl_vld_o, ifc.pxl_eol_o, ifc.pxl_eof_o, busy, ifc.pxl_data_o},
              {1'b1, 4'b0000, 8'h00});
        rst_n = 1'b1;

        for (int unsigned k = 0; k < 8; k++) runFrame(vecs[k], k);

        // Partial frame of 31 pixels, then a one-cycle reset.
        imgWidth  = 11'd16;
        imgHeight = 11'd16;
        for (int k = 0; k < 31; k++) begin
            ifc.rsz_pxl_vld_i  = 1'b1;
            ifc.rsz_pxl_data_i = 8'(k + 150);
            @(negedge clk);
        end
        check("partial busy", {31'd0, busy}, 32'h1);
        rst_n             = 1'b0;
        ifc.rsz_pxl_vld_i = 1'b0;
        @(negedge clk);
        check("mid_reset {rdyIn,busy,vld}", {29'd0, ifc.rsz_pxl_rdy_o, busy, ifc.pxl_vld_o}, 32'h4);
        rst_n = 1'b1;
        runFrame('{w: 8, h: 8, bw: 1, bh: 1, stall: 1'b0, seed: 3}, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
